lsu_mem_bridge: RTL
===================

Name: lsu_mem_bridge

Overview:
- Load/store unit sitting directly downstream of the single-cycle datapath's data-memory port.
- Takes the ALU address, store data, memRead/memWrite and funct3 from the core.
- Performs byte/halfword/word lane steering and load sign/zero extension.
- Talks to a variable-latency word-wide memory over a req/ready handshake, and stalls the core (PC and register-file write enables) until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte-address width from the core.
- DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before a bus error is declared; must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_read  in  1  core load request (memRead).
- req_write  in  1  core store request (memWrite).
- funct3  in  3  access size/sign from the instruction.
- addr  in  ADDR_WIDTH  byte address (aluOut).
- wdata  in  DATA_WIDTH  store data (readData2).
- rdata  out  DATA_WIDTH  extended load result, registered.
- stall  out  1  core must hold PC and suppress register writes.
- misaligned  out  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_error  out  1  one-cycle pulse: memory timeout.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH-2  word address, equal to addr[ADDR_WIDTH-1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-steered store data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ready is high.

Behaviour:
- Reset (asynchronous, rstn low):
  - state = IDLE.
  - rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata, misaligned, bus_error and the timeout counter all go to 0.
  - Reset in the middle of an access abandons it; no completion pulse is produced.
- Access decode:
  - Accepted funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Accepted funct3 for stores: 000 SB, 001 SH, 010 SW.
  - Alignment: halfword accesses need addr[0]=0; word accesses need addr[1:0]=00.
  - If req_read and req_write are both high, the write wins.
- State machine, IDLE:
  - Request present and legal: register mem_req=1 and mem_we, mem_addr, mem_be, mem_wdata; go to WAIT. stall=1 (combinational) in this same cycle.
  - Request present but misaligned or illegal funct3: misaligned=1 for one cycle, no memory access, stall=0, stay in IDLE.
  - No request: stall=0.
- State machine, WAIT:
  - stall=1.
  - Memory-side outputs are held stable.
  - The timeout counter increments every cycle.
  - mem_ready=1: mem_req drops to 0 on the next edge. For a load, the extended result is written into rdata. Go to DONE.
  - Counter reaches TIMEOUT without mem_ready: bus_error=1 for one cycle, rdata=0, mem_req dropped, go to DONE.
- State machine, DONE:
  - stall=0 for exactly one cycle, so the core commits with rdata valid; the core uses the mux selection from memToReg.
  - Unconditionally return to IDLE.
  - The request still visible from the core during DONE is not re-issued.
- Lane steering:
  - SB: mem_be = 0001 shifted left by addr[1:0]; the byte is replicated on all four lanes.
  - SH: mem_be = 0011 or 1100, selected by addr[1]; the halfword is replicated on both halves.
  - SW: mem_be = 1111.
  - Loads: mem_be = 1111.
- Load extension:
  - The byte or halfword is selected by addr[1:0] or addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Timing:
  - Minimum access latency is 2 stall-free-to-commit cycles: the IDLE issue cycle plus one WAIT cycle when mem_ready comes back on the first WAIT cycle.
  - The core sees stall high for 1 + (number of WAIT cycles).
- rdata holds its value between loads. Stores do not modify rdata.

Test Plan:
- LW at addr 0x0000_0010, memory returns 0xDEADBEEF after 3 WAIT cycles.
  - Required: mem_addr=0x4, mem_be=1111, stall high for 4 cycles; in the DONE cycle rdata=0xDEADBEEF and stall=0.
- LB at addr 0x0000_0013 with mem_rdata=0x80FF_7F01 (mem_ready immediate).
  - Required: rdata=0xFFFF_FF80. Repeating as LBU gives rdata=0x0000_0080.
- SH at addr 0x0000_0022 with wdata=0x1234_ABCD.
  - Required: mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x8.
- LW at addr 0x0000_0006.
  - Required: misaligned pulses for 1 cycle, mem_req stays 0, stall stays 0.
- LW with mem_ready held low and TIMEOUT=16.
  - Required: bus_error pulses after 16 WAIT cycles, rdata=0, the next cycle is DONE with stall=0, then the FSM returns to IDLE.
- rstn asserted on the second WAIT cycle of an SW.
  - Required: mem_req=0 and stall=0 immediately; after release the FSM is in IDLE and no bus_error or misaligned pulse appears.

Source files
------------

// File: rtl/lsu_mem_bridge.sv
// rtl/lsu_mem_bridge.sv - load/store unit bridging the core data port to a variable-latency word memory
module lsu_mem_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clock,
   input  logic                  rstn,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  misaligned,
   output logic                  bus_error,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-3:0] addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic                  mis_q, mis_d;
   logic                  berr_q, berr_d;

   logic                  req_any, f3_ok, align_ok, legal;
   logic [3:0]            be_nx;
   logic [DATA_WIDTH-1:0] wd_nx;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] load_ext;

   assign req_any = req_read | req_write;

   // A store wins over a simultaneous load, so decode treats req_write as the access type.
   always_comb begin
      f3_ok = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~req_write;
         default:                f3_ok = 1'b0;
      endcase
      align_ok = 1'b1;
      case (funct3[1:0])
         2'b01:   align_ok = ~addr[0];
         2'b10:   align_ok = (addr[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
      legal = f3_ok & align_ok;
   end

   always_comb begin
      be_nx = 4'b1111;
      wd_nx = '0;
      if (req_write) begin
         case (funct3[1:0])
            2'b00: begin
               be_nx = 4'b0001 << addr[1:0];
               wd_nx = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_nx = addr[1] ? 4'b1100 : 4'b0011;
               wd_nx = {2{wdata[15:0]}};
            end
            default: begin
               be_nx = 4'b1111;
               wd_nx = wdata;
            end
         endcase
      end
   end

   always_comb begin
      ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'b0, ld_byte};
         3'b101:  load_ext = {16'b0, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               if (legal) begin
                  req_d   = 1'b1;
                  we_d    = req_write;
                  addr_d  = addr[ADDR_WIDTH-1:2];
                  be_d    = be_nx;
                  wdata_d = wd_nx;
                  f3_d    = funct3;
                  off_d   = addr[1:0];
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  mis_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_DONE;
               if (!we_q) rdata_d = load_ext;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               berr_d  = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // The request still held by the core here belongs to the committing instruction.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   assign stall      = rstn & (((state_q == S_IDLE) & req_any & legal) | (state_q == S_WAIT));
   assign rdata      = rdata_q;
   assign misaligned = mis_q;
   assign bus_error  = berr_q;
   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_be     = be_q;
   assign mem_wdata  = wdata_q;

endmodule
